// File: rtl/input_mems_pingpong.sv
// Double-buffered A/B operand store: an AXI-stream loader fills one bank while
// the consumer reads the other; banks swap on load completion / compute_finished.
module input_mems_pingpong #(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int KB  = $clog2(MAXK + 1),
  localparam int AAB = $clog2(M * MAXK),
  localparam int BAB = $clog2(MAXK * N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INW-1:0]        AXIS_TDATA,
  input  logic                  AXIS_TVALID,
  input  logic [KB:0]           AXIS_TUSER,
  output logic                  AXIS_TREADY,
  output logic                  matrices_loaded,
  input  logic                  compute_finished,
  output logic [KB-1:0]         K,
  input  logic [AAB-1:0]        A_read_addr,
  output logic signed [INW-1:0] A_data,
  input  logic [BAB-1:0]        B_read_addr,
  output logic signed [INW-1:0] B_data,
  output logic [1:0]            state_o
);

  // Handshake: a word transfers on a rising edge where AXIS_TVALID and
  // AXIS_TREADY are both 1; AXIS_TREADY never depends on AXIS_TVALID.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_A = 2'd1, LOAD_B = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [AAB-1:0]     a_addr_q, a_addr_d;
  logic [BAB-1:0]     b_addr_q, b_addr_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic [1:0][KB-1:0] k_q, k_d;

  logic               accept, new_a, k_ok, done;
  logic [KB-1:0]      k_in, k_sel;
  logic [AAB-1:0]     a_last, a_wa;
  logic [BAB-1:0]     b_last, b_wa;
  logic               a_we, b_we;

  logic signed [INW-1:0] a_mem [2][2**AAB];
  logic signed [INW-1:0] b_mem [2][2**BAB];

  assign AXIS_TREADY     = !reset && !full_q[wr_bank_q];
  assign matrices_loaded = full_q[rd_bank_q];
  assign K               = matrices_loaded ? k_q[rd_bank_q] : '0;
  assign state_o         = state_q;

  assign accept = AXIS_TVALID && AXIS_TREADY;
  assign new_a  = AXIS_TUSER[0];
  assign k_in   = AXIS_TUSER[KB:1];
  assign k_ok   = (k_in != '0) && (k_in <= KB'(MAXK));
  // The first word of a set uses the incoming K; later words use the captured one.
  assign k_sel  = (state_q == IDLE) ? k_in : k_q[wr_bank_q];
  assign a_last = AAB'(M) * AAB'(k_sel) - AAB'(1);
  assign b_last = BAB'(N) * BAB'(k_sel) - BAB'(1);

  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    k_d       = k_q;
    a_we      = 1'b0;
    b_we      = 1'b0;
    a_wa      = a_addr_q;
    b_wa      = b_addr_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && k_ok) begin
          k_d[wr_bank_q] = k_in;
          if (new_a) begin
            a_we = 1'b1;
            a_wa = '0;
            if (a_last == '0) begin
              state_d  = LOAD_B;
              b_addr_d = '0;
            end else begin
              state_d  = LOAD_A;
              a_addr_d = AAB'(1);
            end
          end else begin
            b_we = 1'b1;
            b_wa = '0;
            if (b_last == '0) begin
              done = 1'b1;
            end else begin
              state_d  = LOAD_B;
              b_addr_d = BAB'(1);
            end
          end
        end
      end
      LOAD_A: begin
        if (accept) begin
          a_we = 1'b1;
          if (a_addr_q == a_last) begin
            state_d  = LOAD_B;
            a_addr_d = '0;
            b_addr_d = '0;
          end else begin
            a_addr_d = a_addr_q + AAB'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          b_we = 1'b1;
          if (b_addr_q == b_last) done = 1'b1;
          else b_addr_d = b_addr_q + BAB'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      state_d           = IDLE;
      a_addr_d          = '0;
      b_addr_d          = '0;
    end
    // A completing load always targets the non-full bank, so this never collides.
    if (compute_finished && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      k_q       <= k_d;
    end
  end

  // Storage is deliberately not reset: an abandoned set simply gets overwritten.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[wr_bank_q][a_wa] <= AXIS_TDATA;
    if (b_we) b_mem[wr_bank_q][b_wa] <= AXIS_TDATA;
    A_data <= a_mem[rd_bank_q][A_read_addr];
    B_data <= b_mem[rd_bank_q][B_read_addr];
  end

endmodule

// File: tb/tb_input_mems_pingpong.sv
// Directed bench for input_mems_pingpong: table of single-set loads plus
// hand sequences for ping-pong, overlap, A reuse, illegal K and mid-load reset.
module tb_input_mems_pingpong;
  localparam int INW = 12, M = 7, N = 9, MAXK = 8;
  localparam int KB = 4, AAB = 6, BAB = 7;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [INW-1:0]        AXIS_TDATA;
  logic                  AXIS_TVALID;
  logic [KB:0]           AXIS_TUSER;
  logic                  AXIS_TREADY;
  logic                  matrices_loaded;
  logic                  compute_finished;
  logic [KB-1:0]         K;
  logic [AAB-1:0]        A_read_addr;
  logic signed [INW-1:0] A_data;
  logic [BAB-1:0]        B_read_addr;
  logic signed [INW-1:0] B_data;
  logic [1:0]            state_o;

  input_mems_pingpong #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TUSER(AXIS_TUSER),
    .AXIS_TREADY(AXIS_TREADY), .matrices_loaded(matrices_loaded),
    .compute_finished(compute_finished), .K(K),
    .A_read_addr(A_read_addr), .A_data(A_data),
    .B_read_addr(B_read_addr), .B_data(B_data), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [INW-1:0] exp_q[$];

  typedef struct {
    int             k;
    int             base;
    int             a_addr;
    int             b_addr;
    logic [INW-1:0] exp_a;
    logic [INW-1:0] exp_b;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All driver tasks start and end on a falling edge.
  task automatic send_word(input logic [INW-1:0] d, input logic [KB:0] u);
    int w = 0;
    AXIS_TDATA  = d;
    AXIS_TUSER  = u;
    AXIS_TVALID = 1'b1;
    while (!AXIS_TREADY && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!AXIS_TREADY) chk("tready_wait", 32'(AXIS_TREADY), 32'd1);
    @(negedge clk);
  endtask

  task automatic load_set(input int k, input bit new_a, input int base, input bit cf_last);
    int n = (new_a ? M * k : 0) + k * N;
    for (int i = 0; i < n; i++) begin
      if (cf_last && i == n - 1) compute_finished = 1'b1;
      send_word(INW'(base + i), {KB'(k), new_a});
      compute_finished = 1'b0;
    end
    AXIS_TVALID = 1'b0;
  endtask

  task automatic pulse_cf();
    compute_finished = 1'b1;
    @(negedge clk);
    compute_finished = 1'b0;
  endtask

  task automatic read_a(input string name, input int addr, input logic [INW-1:0] exp);
    exp_q.push_back(exp);
    A_read_addr = AAB'(addr);
    @(negedge clk);
    chk(name, 32'($unsigned(A_data)), 32'(exp_q.pop_front()));
  endtask

  task automatic read_b(input string name, input int addr, input logic [INW-1:0] exp);
    exp_q.push_back(exp);
    B_read_addr = BAB'(addr);
    @(negedge clk);
    chk(name, 32'($unsigned(B_data)), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tready", 32'(AXIS_TREADY), 32'd0);
    chk("rst_loaded", 32'(matrices_loaded), 32'd0);
    chk("rst_k", 32'(K), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 32'(AXIS_TREADY), 32'd1);
    chk("post_rst_loaded", 32'(matrices_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // A data word i of a set is base+i; B word j follows the M*K A words.
    vecs[0] = '{k: 2, base: 'h100, a_addr: 13, b_addr: 17, exp_a: 12'h10D, exp_b: 12'h11F};
    vecs[1] = '{k: 1, base: 'h200, a_addr: 6,  b_addr: 8,  exp_a: 12'h206, exp_b: 12'h20F};
    vecs[2] = '{k: 8, base: 'h7F0, a_addr: 55, b_addr: 71, exp_a: 12'h827, exp_b: 12'h86F};
    vecs[3] = '{k: 3, base: 'hFF0, a_addr: 0,  b_addr: 26, exp_a: 12'hFF0, exp_b: 12'h01F};

    reset = 1'b1; AXIS_TDATA = '0; AXIS_TVALID = 1'b0; AXIS_TUSER = '0;
    compute_finished = 1'b0; A_read_addr = '0; B_read_addr = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      load_set(vecs[i].k, 1'b1, vecs[i].base, 1'b0);
      chk($sformatf("v%0d_loaded", i), 32'(matrices_loaded), 32'd1);
      chk($sformatf("v%0d_k", i), 32'(K), 32'(vecs[i].k));
      chk($sformatf("v%0d_tready", i), 32'(AXIS_TREADY), 32'd1);
      read_a($sformatf("v%0d_a", i), vecs[i].a_addr, vecs[i].exp_a);
      read_b($sformatf("v%0d_b", i), vecs[i].b_addr, vecs[i].exp_b);
      pulse_cf();
      chk($sformatf("v%0d_freed", i), 32'(matrices_loaded), 32'd0);
      chk($sformatf("v%0d_k_zero", i), 32'(K), 32'd0);
    end

    // Ping-pong: both banks full blocks the stream until one is released.
    load_set(3, 1'b1, 'h300, 1'b0);
    load_set(1, 1'b1, 'h400, 1'b0);
    chk("pp_tready_low", 32'(AXIS_TREADY), 32'd0);
    chk("pp_k_first", 32'(K), 32'd3);
    read_b("pp_b_first", 0, 12'h315);
    repeat (3) @(negedge clk);
    chk("pp_still_blocked", 32'(AXIS_TREADY), 32'd0);
    pulse_cf();
    chk("pp_k_second", 32'(K), 32'd1);
    chk("pp_loaded", 32'(matrices_loaded), 32'd1);
    chk("pp_tready_up", 32'(AXIS_TREADY), 32'd1);
    read_a("pp_a_second", 6, 12'h406);
    pulse_cf();
    chk("pp_empty", 32'(matrices_loaded), 32'd0);

    // Overlap: release and completion in the same cycle.
    load_set(1, 1'b1, 'h500, 1'b0);
    load_set(2, 1'b1, 'h600, 1'b1);
    chk("ov_loaded", 32'(matrices_loaded), 32'd1);
    chk("ov_k", 32'(K), 32'd2);
    read_a("ov_a0", 0, 12'h600);
    chk("ov_tready", 32'(AXIS_TREADY), 32'd1);
    pulse_cf();
    chk("ov_empty", 32'(matrices_loaded), 32'd0);

    // A reuse: a B-only set into the same bank keeps the earlier A contents.
    load_set(2, 1'b1, 'h700, 1'b0);
    pulse_cf();
    load_set(1, 1'b1, 'h000, 1'b0);
    pulse_cf();
    load_set(2, 1'b0, 'h800, 1'b0);
    chk("reuse_loaded", 32'(matrices_loaded), 32'd1);
    chk("reuse_k", 32'(K), 32'd2);
    read_a("reuse_a13", 13, 12'h70D);
    read_b("reuse_b0", 0, 12'h800);
    read_b("reuse_b17", 17, 12'h811);
    pulse_cf();

    // Illegal K on the first word is dropped without side effects.
    send_word(12'hEEE, {4'd0, 1'b1});
    send_word(12'hDDD, {4'd9, 1'b1});
    AXIS_TVALID = 1'b0;
    chk("ill_state", 32'(state_o), 32'd0);
    chk("ill_loaded", 32'(matrices_loaded), 32'd0);
    chk("ill_tready", 32'(AXIS_TREADY), 32'd1);
    load_set(1, 1'b1, 'h900, 1'b0);
    chk("ill_then_loaded", 32'(matrices_loaded), 32'd1);
    chk("ill_then_k", 32'(K), 32'd1);
    read_a("ill_a0", 0, 12'h900);
    read_b("ill_b8", 8, 12'h90F);
    pulse_cf();

    // Reset in the middle of a set abandons it.
    for (int i = 0; i < 5; i++) send_word(INW'('hA00 + i), {4'd4, 1'b1});
    AXIS_TVALID = 1'b0;
    do_reset();
    chk("mid_rst_state", 32'(state_o), 32'd0);
    pulse_cf();
    chk("cf_ignored", 32'(matrices_loaded), 32'd0);
    load_set(1, 1'b1, 'hB00, 1'b0);
    chk("mid_rst_loaded", 32'(matrices_loaded), 32'd1);
    chk("mid_rst_k", 32'(K), 32'd1);
    read_a("mid_rst_a0", 0, 12'hB00);
    read_a("mid_rst_a6", 6, 12'hB06);
    read_b("mid_rst_b8", 8, 12'hB0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
